// File: rtl/vga_video_timing_gen.sv
// vga_video_timing_gen
//
// Generates VGA raster timing plus a selectable built-in test pattern on the
// pixel clock. The outputs drive vga2hdmi_sdr directly. Pixel coordinates are
// exported so overlay logic can share the same raster.
//
// Ports:
//   clk_pixel            in   pixel clock; all logic is synchronous to it
//   resetn               in   synchronous active-low reset
//   pattern[1:0]         in   test-pattern select, sampled at pixel (0,0)
//                             0 = colour bars, 1 = checkerboard,
//                             2 = border, 3 = solid blue
//   red_p/green_p/blue_p out  pixel colour, C_depth bits each, 0 when blanked
//   hsync, vsync         out  syncs, active at C_hsync/vsync_polarity
//   blank                out  1 outside the visible area
//   x, y [9:0]           out  current raster position (meaningful when blank=0)
//   frame_start          out  one-cycle pulse at pixel (0,0)
//
// All outputs are registered one stage after the counters and are mutually
// aligned. Raster totals above 1024 in either direction are unsupported.
module vga_video_timing_gen #(
    parameter int C_resolution_x      = 640,
    parameter int C_hsync_front_porch = 16,
    parameter int C_hsync_pulse       = 96,
    parameter int C_hsync_back_porch  = 48,
    parameter int C_resolution_y      = 480,
    parameter int C_vsync_front_porch = 10,
    parameter int C_vsync_pulse       = 2,
    parameter int C_vsync_back_porch  = 33,
    parameter int C_hsync_polarity    = 0,
    parameter int C_vsync_polarity    = 0,
    parameter int C_depth             = 3
) (
    input  logic               clk_pixel,
    input  logic               resetn,
    input  logic [1:0]         pattern,
    output logic [C_depth-1:0] red_p,
    output logic [C_depth-1:0] green_p,
    output logic [C_depth-1:0] blue_p,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic [9:0]         x,
    output logic [9:0]         y,
    output logic               frame_start
);

    localparam int H_TOTAL = C_resolution_x + C_hsync_front_porch + C_hsync_pulse + C_hsync_back_porch;
    localparam int V_TOTAL = C_resolution_y + C_vsync_front_porch + C_vsync_pulse + C_vsync_back_porch;
    localparam int BAR_W   = C_resolution_x / 8;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] RX       = 10'(C_resolution_x);
    localparam logic [9:0] RY       = 10'(C_resolution_y);
    localparam logic [9:0] RX_LAST  = 10'(C_resolution_x - 1);
    localparam logic [9:0] RY_LAST  = 10'(C_resolution_y - 1);
    localparam logic [9:0] HS_START = 10'(C_resolution_x + C_hsync_front_porch);
    localparam logic [9:0] HS_END   = 10'(C_resolution_x + C_hsync_front_porch + C_hsync_pulse);
    localparam logic [9:0] VS_START = 10'(C_resolution_y + C_vsync_front_porch);
    localparam logic [9:0] VS_END   = 10'(C_resolution_y + C_vsync_front_porch + C_vsync_pulse);
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);
    localparam logic       HPOL     = (C_hsync_polarity != 0);
    localparam logic       VPOL     = (C_vsync_polarity != 0);

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic [2:0] bar_b;     // index of the colour bar that hcnt is in
    logic [9:0] bar_cnt;   // pixels left in the current bar, minus one
    logic [1:0] pat_q;

    logic       at_origin;
    logic [1:0] pat_eff;
    logic       visible;
    logic       hs_act;
    logic       vs_act;
    logic       r_bit;
    logic       g_bit;
    logic       b_bit;

    // Raster counters, bar tracker and frame-stable pattern register.
    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            hcnt    <= '0;
            vcnt    <= '0;
            bar_b   <= '0;
            bar_cnt <= BAR_LAST;
            pat_q   <= '0;
        end else begin
            if (at_origin) begin
                pat_q <= pattern;
            end
            if (hcnt == H_LAST) begin
                hcnt    <= '0;
                bar_b   <= '0;
                bar_cnt <= BAR_LAST;
                vcnt    <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
                // Bars advance on a width down-counter so no divider is needed.
                // The index keeps running through blanking; colour is masked there.
                if (bar_cnt == 10'd0) begin
                    bar_b   <= bar_b + 3'd1;
                    bar_cnt <= BAR_LAST;
                end else begin
                    bar_cnt <= bar_cnt - 10'd1;
                end
            end
        end
    end

    // Pixel (0,0) already shows the newly selected pattern, so the pattern
    // input bypasses pat_q on the very cycle it is latched.
    always_comb begin
        at_origin = (hcnt == 10'd0) && (vcnt == 10'd0);
        pat_eff   = at_origin ? pattern : pat_q;
        visible   = (hcnt < RX) && (vcnt < RY);
        hs_act    = (hcnt >= HS_START) && (hcnt < HS_END);
        vs_act    = (vcnt >= VS_START) && (vcnt < VS_END);
        r_bit     = 1'b0;
        g_bit     = 1'b0;
        b_bit     = 1'b0;
        case (pat_eff)
            2'd0: begin
                r_bit = ~bar_b[1];
                g_bit = ~bar_b[2];
                b_bit = ~bar_b[0];
            end
            2'd1: begin
                r_bit = hcnt[5] ^ vcnt[5];
                g_bit = r_bit;
                b_bit = r_bit;
            end
            2'd2: begin
                r_bit = (hcnt == 10'd0) || (hcnt == RX_LAST) ||
                        (vcnt == 10'd0) || (vcnt == RY_LAST);
                g_bit = r_bit;
                b_bit = r_bit;
            end
            default: begin
                b_bit = 1'b1;
            end
        endcase
        if (!visible) begin
            r_bit = 1'b0;
            g_bit = 1'b0;
            b_bit = 1'b0;
        end
    end

    // Output stage: one register after the counters, all outputs aligned.
    always_ff @(posedge clk_pixel) begin
        if (!resetn) begin
            blank       <= 1'b1;
            hsync       <= ~HPOL;
            vsync       <= ~VPOL;
            red_p       <= '0;
            green_p     <= '0;
            blue_p      <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
        end else begin
            blank       <= ~visible;
            hsync       <= hs_act ? HPOL : ~HPOL;
            vsync       <= vs_act ? VPOL : ~VPOL;
            red_p       <= {C_depth{r_bit}};
            green_p     <= {C_depth{g_bit}};
            blue_p      <= {C_depth{b_bit}};
            x           <= hcnt;
            y           <= vcnt;
            frame_start <= at_origin;
        end
    end

endmodule
